// File: rtl/seq_detector_param_if.sv
// Bus bundle for the parametrised sequence detector.
// din is qualified by din_valid alone: a bit is consumed on every rising edge
// where din_valid is high, there is no back-pressure, and din is ignored
// otherwise. The configuration inputs (pattern, pat_len, overlap) are level
// signals that are sampled together with each valid bit.
interface seq_detector_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               din;
    logic               din_valid;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               clear;
    logic               y;
    logic [CNT_W-1:0]   match_count;

    // Stream/config source side
    modport master (
        output din, din_valid, pattern, pat_len, overlap, clear,
        input  y, match_count
    );

    // Detector side
    modport slave (
        input  din, din_valid, pattern, pat_len, overlap, clear,
        output y, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Moore sequence detector with a runtime-programmable pattern of 1..MAX_LEN
// bits, overlap/non-overlap mode, valid qualifier, synchronous clear and a
// saturating match counter. y is registered; there is no path from din to y.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input logic                 clock,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

    // Only MAX_LEN-1 history bits are stored: together with the incoming bit
    // they form the MAX_LEN-bit window that is compared. The oldest bit of
    // that window would be shifted out before it could ever be used again.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-2:0] hist_next;
    logic [MAX_LEN-1:0] hist_shift;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic [LEN_W-1:0]   fill_shift;
    logic               y_reg;
    logic               y_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic               match;

    // Candidate window and match decision for the bit presented this cycle
    always_comb begin
        hist_shift = {hist, bus.din};
        fill_shift = (fill == FULL) ? fill : fill + 1'b1;
        len_mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < bus.pat_len);
        end
        // Out-of-range lengths never match; bits above pat_len are don't-care
        match = (bus.pat_len != '0) && (bus.pat_len <= FULL) &&
                (fill_shift >= bus.pat_len) &&
                (((hist_shift ^ bus.pattern) & len_mask) == '0);
    end

    // Next-state selection: clear beats a valid bit, no valid bit holds all
    always_comb begin
        hist_next  = hist;
        fill_next  = fill;
        y_next     = y_reg;
        count_next = count;
        if (bus.clear) begin
            hist_next  = '0;
            fill_next  = '0;
            y_next     = 1'b0;
            count_next = '0;
        end else if (bus.din_valid) begin
            y_next = match;
            if (match && (count != {CNT_W{1'b1}})) begin
                count_next = count + 1'b1;
            end
            if (match && !bus.overlap) begin
                hist_next = '0;
                fill_next = '0;
            end else begin
                hist_next = hist_shift[MAX_LEN-2:0];
                fill_next = fill_shift;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            fill  <= '0;
            y_reg <= 1'b0;
            count <= '0;
        end else begin
            hist  <= hist_next;
            fill  <= fill_next;
            y_reg <= y_next;
            count <= count_next;
        end
    end

    assign bus.y           = y_reg;
    assign bus.match_count = count;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a reference model and an
// expected-value queue. A narrow counter makes saturation reachable quickly.
module tb_seq_detector_param;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [CNT_W:0] exp_q[$];

    // Reference model state: bits seen since the last flush, newest last
    bit m_hist[$];
    bit m_y   = 1'b0;
    int m_cnt = 0;

    seq_detector_param_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [CNT_W:0] obs,
                         input logic [CNT_W:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_y   = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic v, input logic d, input logic c);
        bit hit;
        int n;
        int len;
        if (c) begin
            model_reset();
        end else if (v) begin
            m_hist.push_back(d);
            if (m_hist.size() > MAX_LEN) m_hist.delete(0);
            len = int'(bus.pat_len);
            n   = m_hist.size();
            hit = (len >= 1) && (len <= MAX_LEN) && (n >= len);
            if (hit) begin
                for (int k = 0; k < len; k++) begin
                    if (m_hist[n-1-k] != bus.pattern[k]) hit = 1'b0;
                end
            end
            m_y = hit;
            if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (hit && !bus.overlap) m_hist.delete();
        end
    endtask

    // Drive one cycle, predict, then compare after the edge
    task automatic step(input string tag, input logic v, input logic d,
                        input logic c);
        logic [CNT_W:0] e;
        bus.din       = d;
        bus.din_valid = v;
        bus.clear     = c;
        model_step(v, d, c);
        exp_q.push_back({m_y, CNT_W'(m_cnt)});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check(tag, {bus.y, bus.match_count}, e);
        bus.din_valid = 1'b0;
        bus.clear     = 1'b0;
    endtask

    task automatic send_bits(input string tag, input logic [15:0] bits,
                             input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], 1'b0);
    endtask

    task automatic config_det(input logic [MAX_LEN-1:0] pat,
                              input int len, input logic ovl);
        bus.pattern = pat;
        bus.pat_len = LEN_W'(len);
        bus.overlap = ovl;
    endtask

    task automatic gap(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.clear     = 1'b0;
        config_det(8'b0000_1101, 4, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", {bus.y, bus.match_count}, '0);
        #2 reset = 1'b0;

        // 1101 with overlap: matches on bits 4 and 7
        send_bits("ovl_1101", 16'b110_1101, 7);
        check("ovl_count", {1'b0, bus.match_count}, {1'b0, CNT_W'(2)});
        check("ovl_y_last", {CNT_W'(0), bus.y}, {CNT_W'(0), 1'b1});

        // Same stream without overlap; upper pattern bits set as don't-care
        step("clr1", 1'b1, 1'b1, 1'b1);
        config_det(8'b1111_1101, 4, 1'b0);
        send_bits("novl_1101", 16'b110_1101, 7);
        check("novl_count", {1'b0, bus.match_count}, {1'b0, CNT_W'(1)});
        check("novl_y_last", {CNT_W'(0), bus.y}, '0);

        // Full-length pattern, then illegal lengths never match
        step("clr2", 1'b0, 1'b0, 1'b1);
        config_det(8'hA5, 8, 1'b1);
        send_bits("a5_len8", 16'hA5, 8);
        check("a5_y", {CNT_W'(0), bus.y}, {CNT_W'(0), 1'b1});
        config_det(8'hA5, 0, 1'b1);
        send_bits("a5_len0", 16'hA5, 8);
        config_det(8'hA5, 9, 1'b1);
        send_bits("a5_len9", 16'hA5, 8);
        check("a5_bad_len_cnt", {1'b0, bus.match_count}, {1'b0, CNT_W'(1)});

        // Valid gaps inside and after a match
        step("clr3", 1'b1, 1'b0, 1'b1);
        config_det(8'b0000_1101, 4, 1'b1);
        send_bits("gap_pre", 16'b11, 2);
        gap("gap_mid", 3);
        send_bits("gap_post", 16'b01, 2);
        gap("gap_hold", 5);
        check("gap_y_held", {CNT_W'(0), bus.y}, {CNT_W'(0), 1'b1});
        step("gap_drop", 1'b1, 1'b0, 1'b0);
        check("gap_y_drop", {CNT_W'(0), bus.y}, '0);

        // Saturating counter with single-bit pattern
        step("clr4", 1'b0, 1'b0, 1'b1);
        config_det(8'b0000_0001, 1, 1'b1);
        send_bits("sat", 16'b11111, 5);
        check("sat_cnt", {bus.y, bus.match_count}, {1'b1, CNT_W'(3)});
        step("clr_discard", 1'b1, 1'b1, 1'b1);
        check("clr_cnt", {bus.y, bus.match_count}, '0);

        // Asynchronous reset mid-stream with a nonzero counter
        config_det(8'b0000_1101, 4, 1'b1);
        send_bits("pre_match", 16'b1101, 4);
        send_bits("pre_rst", 16'b110, 3);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_rst", {bus.y, bus.match_count}, '0);
        #2 reset = 1'b0;
        send_bits("post_rst_1", 16'b1, 1);
        check("post_rst_nomatch", {bus.y, bus.match_count}, '0);
        step("clr5", 1'b0, 1'b0, 1'b1);
        send_bits("fresh_1101", 16'b1101, 4);
        check("fresh_match", {bus.y, bus.match_count}, {1'b1, CNT_W'(1)});

        // Randomised stream against the model, reconfigured every 10 steps
        for (int r = 0; r < 6; r++) begin
            step("rnd_clr", 1'b0, 1'b0, 1'b1);
            config_det(MAX_LEN'($urandom_range(0, 255)),
                       $urandom_range(1, 4), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 10; i++)
                step("rnd", 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore sequence detector, successor to the fixed 1101 detector. Serial bit stream in, with a runtime-programmable pattern (1..MAX_LEN bits) and an overlap/non-overlap mode. Adds a valid qualifier, a synchronous clear and a saturating match counter. Feeds serial-protocol framing and sync-word logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of saturating match counter
LEN_W, $clog2(MAX_LEN+1), width of Pat_len (derived, not overridden)

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Din  input  1  serial data bit
Din_valid  input  1  Din sampled only when high
Pattern  input  MAX_LEN  target pattern; Pattern[Pat_len-1] is the first bit received, Pattern[0] the last
Pat_len  input  LEN_W  active pattern length, legal range 1..MAX_LEN
Overlap  input  1  1 = overlapping matches allowed, 0 = history flushed after each match
Clear  input  1  synchronous clear of history, Y and counter
Y  output  1  Moore match flag (registered)
Match_count  output  CNT_W  saturating count of matches since reset/clear

Behaviour:
- One clock; reset is asynchronous and active-high (ports Clock, Reset).
- State: history shift register H[MAX_LEN-1:0], fill counter F (0..MAX_LEN), Y register, Match_count.
- Reset (async): H=0, F=0, Y=0, Match_count=0. Outputs stay low until the first valid bit is sampled after deassertion.
- Clear=1 at a rising edge: H=0, F=0, Y=0, Match_count=0. Din is discarded that cycle, even if Din_valid=1. Clear has priority over everything except Reset.
- On a rising edge with Din_valid=1 and Clear=0:
  - Hn = {H[MAX_LEN-2:0], Din}.
  - Fn = min(F+1, MAX_LEN).
  - match = (1 <= Pat_len <= MAX_LEN) && (Fn >= Pat_len) && (Hn[Pat_len-1:0] == Pattern[Pat_len-1:0]).
  - Y <= match.
  - If match, Match_count <= Match_count+1, saturating at 2^CNT_W-1 (no wrap).
  - If match && Overlap=0: H <= 0, F <= 0. Otherwise H <= Hn, F <= Fn.
- On a rising edge with Din_valid=0 and Clear=0: H, F, Y and Match_count all hold. Moore semantics: Y stays high across valid gaps until the next sampled bit.
- Latency: Y rises on the clock edge that samples the last pattern bit, i.e. it is visible in the cycle after that bit is presented. No combinational path from Din to Y.
- Pat_len=0 or Pat_len>MAX_LEN: no match is ever reported. H and F still shift and fill.
- Pattern, Pat_len and Overlap are sampled live on every valid edge. Changing them mid-stream does not flush history; software asserts Clear when reconfiguring.
- Only the low Pat_len bits of Pattern are compared. Upper bits are don't-care.
- Reset asserted mid-stream: immediate return to the reset state with no partial-match carry-over.

Test Plan:
- Pattern=8'b00001101, Pat_len=4, Overlap=1, stream 1,1,0,1,1,0,1 (all valid) -> Y high after the 4th and 7th bits, low otherwise; Match_count=2.
- Same stream with Overlap=0 -> Y high only after the 4th bit; Match_count=1.
- Pat_len=8, Pattern=8'hA5, stream 1,0,1,0,0,1,0,1 -> Y high after the 8th bit only. Change Pat_len to 0 and stream A5 again -> Y never rises.
- 1101 with Din_valid=0 for 3 cycles between the 2nd and 3rd bits and for 5 cycles after the match -> match still detected; Y stays high through all 5 gap cycles and drops on the next valid 0.
- CNT_W=2, Overlap=1, pattern "1" (Pat_len=1), five valid 1s -> Match_count goes 1,2,3,3,3 and Y stays high. Then Clear with Din_valid=1, Din=1 -> Y=0, Match_count=0, bit discarded.
- Feed 1,1,0, assert Reset asynchronously mid-cycle, release, feed 1 -> no match; Y=0 and Match_count=0 immediately on Reset. A fresh 1101 then matches.
